pkt_capture_ctrl: RTL
=====================

# pkt_capture_ctrl

Capture/readback controller sitting directly upstream of the packet-controller SRAM wrapper (32768x36 single-port, active-low CEB/WEB, 1-cycle read latency). It writes a stream of packed ADC words into consecutive SRAM addresses on a start command. After capture completes, it serves random-access read requests from the host side over the same single port. Parent instantiates this block and the SRAM wrapper side by side.

## Interface
- ADDR_WIDTH, 15, SRAM address width
- DATA_WIDTH, 36, SRAM word width
- CLK  in  1  sole clock, rising edge
- RSTN  in  1  synchronous active-low reset
- cfg_start  in  1  one-cycle pulse: begin capture at address 0
- cfg_len  in  ADDR_WIDTH  words to capture minus 1 (0 -> 1 word, all-ones -> 32768); latched on accepted cfg_start
- in_valid  in  1  in_data valid this cycle
- in_data  in  DATA_WIDTH  packed sample word
- rd_req  in  1  read request, accepted when rd_ready=1
- rd_addr  in  ADDR_WIDTH  read address
- rd_ready  out  1  high in IDLE/DONE
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_WIDTH  read word
- busy  out  1  high in CAPTURE
- done  out  1  sticky capture-complete flag
- wr_ptr  out  ADDR_WIDTH  next write address
- MEM_CEB / MEM_WEB  out  1  SRAM chip/write enable, active-low, registered
- MEM_A  out  ADDR_WIDTH  SRAM address, registered
- MEM_D  out  DATA_WIDTH  SRAM write data, registered
- MEM_Q  in  DATA_WIDTH  SRAM read data

## Operation
- States: IDLE, CAPTURE, DONE. Reset -> IDLE.
- IDLE/DONE + cfg_start -> CAPTURE; wr_ptr<=0, len latched, done<=0. cfg_start has priority over rd_req in the same cycle; that read is dropped (no rd_valid).
- CAPTURE: each in_valid cycle -> one SRAM write at wr_ptr, wr_ptr+1. Write with wr_ptr==latched len -> DONE, done<=1. in_valid outside CAPTURE is discarded.
- cfg_start during CAPTURE ignored. rd_req during CAPTURE ignored (rd_ready=0).
- IDLE/DONE + rd_req -> one SRAM read at rd_addr; back-to-back reads every cycle allowed.
- wr_ptr increments modulo 2^ADDR_WIDTH; with full-depth len the final write is address 32767 and wr_ptr wraps to 0 on entry to DONE.
- No cycle issues both read and write (port is single).

## Timing
- Reset values: MEM_CEB=1, MEM_WEB=1, MEM_A=0, MEM_D=0, rd_valid=0, busy=0, done=0, wr_ptr=0, rd_ready=1 (IDLE).
- Write: in_valid at cycle t -> MEM_CEB=0, MEM_WEB=0, MEM_A/MEM_D driven during t+1.
- Read: rd_req at t -> MEM_CEB=0, MEM_WEB=1 during t+1 -> rd_valid=1, rd_data=MEM_Q during t+2 (rd_data passthrough of MEM_Q). Latency 2.
- busy rises cycle after cfg_start; done rises cycle after last accepted in_valid, same cycle as the last SRAM write strobe.
- Idle cycles: MEM_CEB=1, MEM_WEB=1; MEM_A/MEM_D hold.
- RSTN low mid-capture: next edge forces IDLE, MEM_CEB=1; any in-flight read's rd_valid cleared.

## Configuration
- CAPTURE_WRAP_EN defined: extra input cfg_stop (1 bit). Capture ignores cfg_len, writes continuously wrapping at 2^ADDR_WIDTH, ends on cfg_stop (cfg_stop coincident with in_valid: that word is written, then DONE). wr_ptr then marks the oldest word.
- Undefined: no cfg_stop port; single-shot behaviour above.

## Structure
- Shared package pkt_capture_pkg: state enum (IDLE/CAPTURE/DONE), default ADDR_WIDTH/DATA_WIDTH constants.
- Single flat module; no sub-module. SRAM wrapper instantiated by parent.

## Test plan
- Reset, then idle 10 cycles -> MEM_CEB=1 throughout, rd_ready=1, done=0.
- cfg_len=3, cfg_start, 4 in_valid words 0x1,0x2,0x3,0x4 with gaps -> writes to A=0..3, done=1, wr_ptr=4; reads 0..3 back-to-back -> rd_data 0x1..0x4 at 2-cycle latency.
- cfg_len=all-ones, 32768 continuous words (data=addr) -> last write A=32767, wr_ptr=0, done=1; read 32767 -> 0x07FFF.
- rd_req during CAPTURE and cfg_start with rd_req in IDLE -> no SRAM read, no rd_valid.
- RSTN low after 2 of 5 capture writes -> IDLE, done=0, wr_ptr=0, no further SRAM strobes.
- CAPTURE_WRAP_EN: 32770 words then cfg_stop -> addresses 0,1 overwritten, wr_ptr=2, done=1.

Source files
------------

// File: rtl/pkt_capture_pkg.sv
// -----------------------------------------------------------------------------
// pkt_capture_pkg
// Shared definitions for the packet capture controller:
//   - cap_state_e : capture FSM states (IDLE, CAPTURE, DONE)
//   - DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default SRAM geometry (32768 x 36)
// -----------------------------------------------------------------------------
package pkt_capture_pkg;

  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_DATA_WIDTH = 36;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_e;

endpackage : pkt_capture_pkg

// File: rtl/pkt_capture_ctrl.sv
// -----------------------------------------------------------------------------
// pkt_capture_ctrl
// Capture/readback controller in front of a single-port SRAM (active-low
// CEB/WEB, 1-cycle read latency). On cfg_start it writes the incoming in_data
// stream to consecutive addresses from 0; once capture has finished it serves
// random-access host reads over the same port.
//
// Ports:
//   CLK, RSTN            clock (rising edge), synchronous active-low reset
//   cfg_start, cfg_len   start pulse, word count minus 1 (latched on start)
//   cfg_stop             (CAPTURE_WRAP_EN only) end a wrapping capture
//   in_valid, in_data    sample stream, accepted only while capturing
//   rd_req, rd_addr      host read request, accepted when rd_ready=1
//   rd_ready, rd_valid   read handshake; rd_data is MEM_Q passed through
//   busy, done, wr_ptr   capture status and next write address
//   MEM_CEB/WEB/A/D, MEM_Q  registered SRAM strobes, address, data; read data
//
// Build option: define CAPTURE_WRAP_EN to replace the length-bounded capture
// by a continuous, address-wrapping capture that ends on cfg_stop.
// -----------------------------------------------------------------------------
module pkt_capture_ctrl
  import pkt_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_len,
`ifdef CAPTURE_WRAP_EN
  input  logic                  cfg_stop,
`endif
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  MEM_CEB,
  output logic                  MEM_WEB,
  output logic [ADDR_WIDTH-1:0] MEM_A,
  output logic [DATA_WIDTH-1:0] MEM_D,
  input  logic [DATA_WIDTH-1:0] MEM_Q
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  cap_state_e            state_r, state_s;
  logic [ADDR_WIDTH-1:0] len_r, len_s;
  logic [ADDR_WIDTH-1:0] wr_ptr_r, wr_ptr_s;
  logic                  done_r, done_s;
  logic                  mem_ceb_r, mem_ceb_s;
  logic                  mem_web_r, mem_web_s;
  logic [ADDR_WIDTH-1:0] mem_a_r, mem_a_s;
  logic [DATA_WIDTH-1:0] mem_d_r, mem_d_s;
  logic                  rd_valid_r;
  logic                  last_wr_s;
  logic                  stop_s;

  // End-of-capture conditions: length match in single-shot mode, cfg_stop in wrap mode.
  always_comb begin
    last_wr_s = 1'b0;
    stop_s    = 1'b0;
`ifdef CAPTURE_WRAP_EN
    stop_s    = cfg_stop;
`else
    last_wr_s = (wr_ptr_r == len_r);
`endif
  end

  // Next-state and next-strobe logic; the SRAM port is granted to exactly one of write/read/none.
  always_comb begin
    state_s   = state_r;
    len_s     = len_r;
    wr_ptr_s  = wr_ptr_r;
    done_s    = done_r;
    mem_ceb_s = 1'b1;
    mem_web_s = 1'b1;
    mem_a_s   = mem_a_r;
    mem_d_s   = mem_d_r;
    case (state_r)
      IDLE, DONE: begin
        if (cfg_start) begin
          // Start wins over a coincident read; that read is simply dropped.
          state_s  = CAPTURE;
          len_s    = cfg_len;
          wr_ptr_s = '0;
          done_s   = 1'b0;
        end else if (rd_req) begin
          mem_ceb_s = 1'b0;
          mem_a_s   = rd_addr;
        end else begin
          mem_ceb_s = 1'b1;
        end
      end
      CAPTURE: begin
        if (in_valid) begin
          mem_ceb_s = 1'b0;
          mem_web_s = 1'b0;
          mem_a_s   = wr_ptr_r;
          mem_d_s   = in_data;
          wr_ptr_s  = wr_ptr_r + ADDR_ONE;
          if (last_wr_s || stop_s) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            state_s = CAPTURE;
          end
        end else if (stop_s) begin
          state_s = DONE;
          done_s  = 1'b1;
        end else begin
          state_s = CAPTURE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, status and SRAM port registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_r    <= IDLE;
      len_r      <= '0;
      wr_ptr_r   <= '0;
      done_r     <= 1'b0;
      mem_ceb_r  <= 1'b1;
      mem_web_r  <= 1'b1;
      mem_a_r    <= '0;
      mem_d_r    <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      len_r      <= len_s;
      wr_ptr_r   <= wr_ptr_s;
      done_r     <= done_s;
      mem_ceb_r  <= mem_ceb_s;
      mem_web_r  <= mem_web_s;
      mem_a_r    <= mem_a_s;
      mem_d_r    <= mem_d_s;
      // A read strobe this cycle means MEM_Q holds the word next cycle.
      rd_valid_r <= ~mem_ceb_r & mem_web_r;
    end
  end

  assign busy     = (state_r == CAPTURE);
  assign rd_ready = (state_r != CAPTURE);
  assign done     = done_r;
  assign wr_ptr   = wr_ptr_r;
  assign rd_valid = rd_valid_r;
  assign rd_data  = MEM_Q;
  assign MEM_CEB  = mem_ceb_r;
  assign MEM_WEB  = mem_web_r;
  assign MEM_A    = mem_a_r;
  assign MEM_D    = mem_d_r;

endmodule : pkt_capture_ctrl
